// File: rtl/alu_mult_secuenciador.sv
// alu_mult_secuenciador: shift-add WIDTHxWIDTH unsigned multiplier sequenced over the shared ALU adder
//   clk, reset (async, active-high)
//   inicio, multiplicando, multiplicador : start request and operands, captured in IDLE or DONE
//   alu_operador1/2, alu_selector, alu_resultado : drive/capture of the shared ALU (add only)
//   producto_hi/lo : 2*WIDTH product, held until the next accepted start
//   ocupado : high in the WIDTH iteration cycles; listo : one-cycle done pulse
module alu_mult_secuenciador #(
   parameter int WIDTH = 32,
   parameter logic [3:0] SEL_ADD = 4'b0010,
   parameter logic [3:0] SEL_IDLE = 4'b0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inicio,
   input  logic [WIDTH-1:0] multiplicando,
   input  logic [WIDTH-1:0] multiplicador,
   output logic [WIDTH-1:0] alu_operador1,
   output logic [WIDTH-1:0] alu_operador2,
   output logic [3:0]       alu_selector,
   input  logic [WIDTH-1:0] alu_resultado,
   output logic [WIDTH-1:0] producto_hi,
   output logic [WIDTH-1:0] producto_lo,
   output logic             ocupado,
   output logic             listo
);
   localparam int CW = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] m_q, m_d, p_hi_q, p_hi_d, p_lo_q, p_lo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic carry;
   // The ALU has no carry-out; an unsigned sum that wrapped is smaller than either addend.
   assign carry = alu_resultado < p_hi_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         m_q <= '0;
         p_hi_q <= '0;
         p_lo_q <= '0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         m_q <= m_d;
         p_hi_q <= p_hi_d;
         p_lo_q <= p_lo_d;
         cnt_q <= cnt_d;
      end
   end
   always_comb begin
      state_d = state_q;
      m_d = m_q;
      p_hi_d = p_hi_q;
      p_lo_d = p_lo_q;
      cnt_d = cnt_q;
      alu_operador1 = '0;
      alu_operador2 = '0;
      alu_selector = SEL_IDLE;
      if (state_q == CALC) begin
         alu_operador1 = p_hi_q;
         alu_operador2 = p_lo_q[0] ? m_q : '0;
         alu_selector = SEL_ADD;
         // {carry, sum, P_lo} >> 1: the multiplier bit just consumed falls off the bottom.
         p_hi_d = {carry, alu_resultado[WIDTH-1:1]};
         p_lo_d = {alu_resultado[0], p_lo_q[WIDTH-1:1]};
         cnt_d = cnt_q + CW'(1);
         state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : CALC;
      end else if (inicio) begin
         m_d = multiplicando;
         p_hi_d = '0;
         p_lo_d = multiplicador;
         cnt_d = '0;
         state_d = CALC;
      end else begin
         state_d = IDLE;
      end
   end
   assign producto_hi = p_hi_q;
   assign producto_lo = p_lo_q;
   assign ocupado = (state_q == CALC);
   assign listo = (state_q == DONE);
endmodule

// File: tb/tb_alu_mult_secuenciador.sv
// tb_alu_mult_secuenciador: scoreboard bench for the sequenced multiplier with a behavioural ALU
module tb_alu_mult_secuenciador;
   localparam int W = 32;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic inicio = 1'b0;
   logic [W-1:0] multiplicando = '0, multiplicador = '0;
   logic [W-1:0] alu_operador1, alu_operador2, alu_resultado, producto_hi, producto_lo;
   logic [3:0] alu_selector;
   logic ocupado, listo;
   int checks = 0, errors = 0;
   logic [2*W-1:0] sb[$];

   alu_mult_secuenciador #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .inicio(inicio),
      .multiplicando(multiplicando), .multiplicador(multiplicador),
      .alu_operador1(alu_operador1), .alu_operador2(alu_operador2),
      .alu_selector(alu_selector), .alu_resultado(alu_resultado),
      .producto_hi(producto_hi), .producto_lo(producto_lo),
      .ocupado(ocupado), .listo(listo)
   );

   // Shared ALU: only the add operation is modelled.
   assign alu_resultado = (alu_selector == 4'b0010) ? alu_operador1 + alu_operador2 : '0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      multiplicando = a;
      multiplicador = b;
      inicio = 1'b1;
      sb.push_back(64'(a) * 64'(b));
   endtask

   // Called at the first negedge after acceptance; returns at the negedge where listo is high.
   task automatic wait_done(input bit zero_op2);
      int busy = 0;
      int n = 0;
      bit sel_ok = 1'b1;
      bit op2_ok = 1'b1;
      logic [2*W-1:0] exp = 'x;
      while (listo !== 1'b1 && n < 40) begin
         if (ocupado === 1'b1) begin
            busy++;
            if (alu_selector !== 4'b0010) sel_ok = 1'b0;
            if (zero_op2 && alu_operador2 !== '0) op2_ok = 1'b0;
         end
         n++;
         @(negedge clk);
      end
      if (sb.size() > 0) exp = sb.pop_front();
      chk("listo_seen", 64'(listo), 64'(1));
      chk("busy_cycles", 64'(busy), 64'(W));
      chk("calc_selector", 64'(sel_ok), 64'(1));
      if (zero_op2) chk("calc_op2_zero", 64'(op2_ok), 64'(1));
      chk("done_state", {ocupado, alu_selector, alu_operador1, alu_operador2}, '0);
      chk("product", {producto_hi, producto_lo}, exp);
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input bit zero_op2);
      start_op(a, b);
      @(negedge clk);
      inicio = 1'b0;
      wait_done(zero_op2);
   endtask

   initial begin
      logic [2*W-1:0] held;
      #1;
      chk("reset_outputs", {producto_hi, producto_lo}, '0);
      chk("reset_flags", {ocupado, listo, alu_selector, alu_operador1, alu_operador2}, '0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      op(32'd3, 32'd5, 1'b0);
      held = {producto_hi, producto_lo};
      repeat (3) @(negedge clk);
      chk("idle_hold", {producto_hi, producto_lo}, 64'd15);
      chk("idle_alu", {ocupado, listo, alu_selector, alu_operador1, alu_operador2}, '0);
      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("carry_hi_lo", {producto_hi, producto_lo}, 64'hFFFF_FFFE_0000_0001);
      op(32'h1234_5678, 32'h0, 1'b1);
      start_op(32'd7, 32'd9);
      @(negedge clk);
      multiplicando = 32'd2;
      multiplicador = 32'h8000_0000;
      wait_done(1'b0);
      sb.push_back(64'h1_0000_0000);
      @(negedge clk);
      chk("b2b_no_idle", 64'(ocupado), 64'(1));
      inicio = 1'b0;
      wait_done(1'b0);
      start_op(32'hFFFF, 32'hFFFF);
      @(negedge clk);
      inicio = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("async_reset_prod", {producto_hi, producto_lo}, '0);
      chk("async_reset_flags", {ocupado, listo, alu_selector, alu_operador1, alu_operador2}, '0);
      void'(sb.pop_back());
      @(negedge clk);
      reset = 1'b0;
      op(32'd6, 32'd7, 1'b0);
      chk("after_reset", {producto_hi, producto_lo}, 64'd42);
      for (int i = 0; i < 1000; i++) op($urandom, $urandom, 1'b0);
      chk("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_mult_secuenciador.md
Name: alu_mult_secuenciador

Overview:
Multi-cycle sequencer that performs an unsigned WIDTH x WIDTH multiply using the shared datapath ALU's add operation. It uses one ALU add per iteration, shift-add radix-2, with one iteration per clock. It sits beside the ALU in the datapath: it drives the ALU's operand and selector inputs while busy, and captures the ALU result. It exposes a start/busy/done handshake to the control unit.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH bits.
SEL_ADD, 4'b0010, ALU selector code for add.
SEL_IDLE, 4'b0000, ALU selector driven when the block is not computing.

Ports:
clk  input  1  clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-high reset.
inicio  input  1  start request; sampled only in IDLE or DONE.
multiplicando  input  WIDTH  multiplicand; captured at accepted inicio.
multiplicador  input  WIDTH  multiplier; captured at accepted inicio.
alu_operador1  output  WIDTH  to ALU operador1.
alu_operador2  output  WIDTH  to ALU operador2.
alu_selector  output  4  to ALU selector.
alu_resultado  input  WIDTH  from ALU resultado; combinational path, same cycle.
producto_hi  output  WIDTH  upper half of the product.
producto_lo  output  WIDTH  lower half of the product.
ocupado  output  1  high while computing.
listo  output  1  one-cycle done pulse.

Behaviour:
- Internal registers:
  - M (WIDTH): captured multiplicand.
  - P_hi, P_lo (WIDTH each): accumulator / multiplier register.
  - cnt (log2(WIDTH)+1 bits): iteration counter.
  - state: IDLE, CALC, DONE.
- Reset (async, any time including mid-CALC):
  - state=IDLE, M=P_hi=P_lo=cnt=0.
  - ocupado=0, listo=0.
  - producto_hi=producto_lo=0.
  - alu_operador1=alu_operador2=0, alu_selector=SEL_IDLE.
- IDLE:
  - inicio=1 at an edge: M<=multiplicando, P_hi<=0, P_lo<=multiplicador, cnt<=0, state<=CALC.
  - inicio=0: stay in IDLE.
- CALC (exactly WIDTH cycles):
  - Combinational ALU drive: alu_operador1=P_hi; alu_operador2 = P_lo[0] ? M : 0; alu_selector=SEL_ADD.
  - Carry: c = (alu_resultado < P_hi), unsigned compare. The ALU is WIDTH bits and produces no carry, so the block derives it this way. When P_lo[0]=0, the sum equals P_hi and c=0.
  - At the edge: {P_hi,P_lo} <= {c, alu_resultado, P_lo} >> 1 (a 2*WIDTH+1 bit vector shifted right by one, keeping the low 2*WIDTH bits). Then cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge: state<=DONE.
  - inicio is ignored throughout CALC.
- DONE (one cycle):
  - listo=1.
  - alu_selector=SEL_IDLE, ALU operands=0.
  - inicio=1 at this edge: restarts exactly as in IDLE (back-to-back operation). Otherwise state<=IDLE.
- Outputs:
  - producto_hi=P_hi and producto_lo=P_lo, driven directly from the registers.
  - ocupado=(state==CALC).
  - listo=(state==DONE).
  - The product is held stable in IDLE until the next accepted inicio.
- Latency: inicio is accepted at edge k; the iterations occur at edges k+1 through k+WIDTH; the product is valid and listo is high from edge k+WIDTH until k+WIDTH+1. Total latency is WIDTH+1 cycles.
- ALU sharing: outside CALC the block drives neutral values on the ALU inputs. External muxing onto the ALU selects this block whenever ocupado=1.
- Operands are unsigned only. The ALU zero flag is unused.

Test Plan:
- Small operands: multiplicando=3, multiplicador=5, pulse inicio -> listo at cycle 33 after acceptance; producto_hi=0, producto_lo=15; ocupado high for exactly 32 cycles.
- Carry path: 0xFFFFFFFF x 0xFFFFFFFF -> producto_hi=0xFFFFFFFE, producto_lo=0x00000001.
- Zero operand: 0x12345678 x 0 -> product 0. In every CALC cycle alu_operador2=0 and alu_selector=4'b0010.
- Ignored restart: inicio held high throughout CALC of 7 x 9 -> the result is 63 and the operands are not recaptured. A new operation with 2 x 0x80000000 then starts on the DONE edge -> producto_hi=1, producto_lo=0 after 33 more cycles, with no IDLE cycle between the two operations.
- Reset mid-operation: assert reset at iteration 10 of 0xFFFF x 0xFFFF -> all outputs clear immediately (asynchronous), state returns to IDLE. After reset is released, a new 6 x 7 operation -> 42.
- Golden-model check: 1000 random operand pairs checked against a 64-bit reference multiply. Check listo, ocupado and ALU selector timing on every operation.
